// File: rtl/seq_slice_adder_pkg.sv
// Shared constants, FSM state encoding and the decoder-based full-adder helper
// for the byte-serial adder.
package seq_slice_adder_pkg;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_SLICE = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Full adder from a 3-to-8 decoder: sum ORs minterms 1,2,4,7; carry ORs 3,5,6,7.
  // Returns {carry, sum}.
  function automatic logic [1:0] fa_dec(input logic x, input logic y, input logic ci);
    logic [7:0] dec;
    dec = 8'd1 << 3'({x, y, ci});
    return {dec[3] | dec[5] | dec[6] | dec[7], dec[1] | dec[2] | dec[4] | dec[7]};
  endfunction

endpackage

// File: rtl/seq_slice_adder_if.sv
// Operand and result handshake bundle for seq_slice_adder.
// The ovf signal exists only when SEQ_SLICE_ADDER_OVF_EN is defined.
interface seq_slice_adder_if #(
  parameter int unsigned WIDTH = seq_slice_adder_pkg::DEF_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SEQ_SLICE_ADDER_OVF_EN
  logic             ovf;
`endif

  modport master (
    output in_valid, a, b, cin, out_ready,
`ifdef SEQ_SLICE_ADDER_OVF_EN
    input  ovf,
`endif
    input  in_ready, out_valid, sum, cout
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
`ifdef SEQ_SLICE_ADDER_OVF_EN
    output ovf,
`endif
    output in_ready, out_valid, sum, cout
  );

endinterface

// File: rtl/seq_slice_adder_adder_8bit.sv
// 8-bit ripple slice built from decoder-based full adders.
module adder_8bit
  import seq_slice_adder_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       ci,
  output logic [7:0] s,
  output logic       co
);

  logic [8:0] c;
  logic [1:0] fa;

  always_comb begin
    c    = '0;
    s    = '0;
    fa   = '0;
    c[0] = ci;
    for (int i = 0; i < 8; i++) begin
      fa     = fa_dec(a[i], b[i], c[i]);
      s[i]   = fa[0];
      c[i+1] = fa[1];
    end
  end

  assign co = c[8];

endmodule

// File: rtl/seq_slice_adder.sv
// Byte-serial 32-bit adder: one SLICE-wide ripple slice per clock, carry kept in a flop.
// Optional signed overflow output enabled by SEQ_SLICE_ADDER_OVF_EN.
module seq_slice_adder
  import seq_slice_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned SLICE = DEF_SLICE
) (
  input  logic               clk,
  input  logic               rst_n,
  seq_slice_adder_if.slave   bus
);

  localparam int unsigned NSLICE = WIDTH / SLICE;
  localparam int unsigned IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NSLICE - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               cout_q, cout_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
`ifdef SEQ_SLICE_ADDER_OVF_EN
  logic               ovf_q, ovf_d;
`endif

  logic [SLICE-1:0]   sl_a, sl_b, sl_s;
  logic               sl_co;

  assign sl_a = a_q[idx_q*SLICE +: SLICE];
  assign sl_b = b_q[idx_q*SLICE +: SLICE];

  // Single shared slice; the legacy 8-bit cell is used whenever the slice is a byte.
  if (SLICE == 8) begin : gen_byte_slice
    adder_8bit u_slice (
      .a  (sl_a),
      .b  (sl_b),
      .ci (carry_q),
      .s  (sl_s),
      .co (sl_co)
    );
  end else begin : gen_slice_adder
    logic [SLICE:0] c;
    logic [1:0]     fa;
    always_comb begin
      c    = '0;
      sl_s = '0;
      fa   = '0;
      c[0] = carry_q;
      for (int i = 0; i < int'(SLICE); i++) begin
        fa      = fa_dec(sl_a[i], sl_b[i], c[i]);
        sl_s[i] = fa[0];
        c[i+1]  = fa[1];
      end
    end
    assign sl_co = c[SLICE];
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    carry_d   = carry_q;
    idx_d     = idx_q;
    cout_d    = cout_q;
`ifdef SEQ_SLICE_ADDER_OVF_EN
    ovf_d     = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          a_d     = bus.a;
          b_d     = bus.b;
          carry_d = bus.cin;
          idx_d   = '0;
          sum_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        sum_d[idx_q*SLICE +: SLICE] = sl_s;
        carry_d = sl_co;
        if (idx_q == IDX_LAST) begin
          idx_d   = '0;
          cout_d  = sl_co;
`ifdef SEQ_SLICE_ADDER_OVF_EN
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_d[WIDTH-1] != a_q[WIDTH-1]);
`endif
          state_d = DONE;
        end else begin
          idx_d = IDX_W'(idx_q + 1'b1);
        end
      end
      DONE: begin
        if (out_valid_q && bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      cout_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef SEQ_SLICE_ADDER_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      idx_q       <= idx_d;
      cout_q      <= cout_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
`ifdef SEQ_SLICE_ADDER_OVF_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
`ifdef SEQ_SLICE_ADDER_OVF_EN
  assign bus.ovf       = ovf_q;
`endif

endmodule
